// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and arbiter hold-slot state type.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_HELD,
    SLOT_ADDR,
    SLOT_DATA
  } slot_state_e;

  function automatic logic is_xfer(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_arb_hold_slot.sv
// Per-master hold slot: captures a losing address phase, stalls the master
// via its own hready and reports its slot state to the arbiter.
module ahb_arb_hold_slot
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    hsize,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic          s_hready,
  input  logic          s_hresp,
  input  logic          grant,
  output logic          req,
  output logic          held,
  output logic [AW-1:0] hold_addr,
  output logic [1:0]    hold_size,
  output logic          hold_write,
  output logic          hready,
  output logic          hresp,
  output slot_state_e   state
);

  slot_state_e state_q, state_d;
  logic        capture;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= SLOT_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hold_addr  <= '0;
      hold_size  <= '0;
      hold_write <= 1'b0;
    end else if (capture) begin
      hold_addr  <= haddr;
      hold_size  <= hsize;
      hold_write <= hwrite;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state_q)
      SLOT_HELD: hready = 1'b0;
      SLOT_DATA: begin
        hready = s_hready;
        hresp  = s_hresp;
      end
      default: ;
    endcase
  end

  // Request gated by reset so a live htrans cannot reach the slave while held in reset
  assign req  = aresetn && hready && is_xfer(htrans);
  assign held = (state_q == SLOT_HELD);

  // ADDR is not registered: it is the granted cycle of a held slot, keeping replay latency at one cycle
  assign state = (held && grant) ? SLOT_ADDR : state_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      SLOT_HELD: if (s_hready && grant) state_d = SLOT_DATA;
      SLOT_DATA: begin
        if (s_hready) begin
          if (!req) begin
            state_d = SLOT_IDLE;
          end else if (grant) begin
            state_d = SLOT_DATA;
          end else begin
            state_d = SLOT_HELD;
            capture = 1'b1;
          end
        end
      end
      default: begin
        if (req) begin
          if (s_hready && grant) begin
            state_d = SLOT_DATA;
          end else begin
            state_d = SLOT_HELD;
            capture = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter onto one slave port with hold-slot replay.
// Define AHB_ARB_RR_EN for round-robin; otherwise fixed priority m0 > m1.
module ahb_lite_arbiter2
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [2*AW-1:0] m_haddr,
  input  logic [3:0]      m_hsize,
  input  logic [3:0]      m_htrans,
  input  logic [1:0]      m_hwrite,
  input  logic [2*DW-1:0] m_hwdata,
  output logic [1:0]      m_hready,
  output logic [DW-1:0]   m_hrdata,
  output logic [1:0]      m_hresp,
  output logic [AW-1:0]   s_haddr,
  output logic [1:0]      s_hsize,
  output logic [1:0]      s_htrans,
  output logic            s_hwrite,
  output logic [DW-1:0]   s_hwdata,
  input  logic            s_hready,
  input  logic [DW-1:0]   s_hrdata,
  input  logic            s_hresp,
  output logic [1:0]      owner
);

  logic [AW-1:0] live_addr  [2];
  logic [1:0]    live_size  [2];
  logic [1:0]    live_trans [2];
  logic [AW-1:0] hold_addr  [2];
  logic [1:0]    hold_size  [2];
  slot_state_e   st         [2];
  logic [1:0]    hold_write, req, held, cand, grant;
  logic          gnt0, gnt1, win, prio_m1;
  logic          dp_valid, dp_idx;

  logic [AW-1:0] bus_addr, bus_addr_q;
  logic [1:0]    bus_size, bus_size_q, bus_trans, bus_trans_q;
  logic          bus_write, bus_write_q;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign live_addr[g]  = m_haddr[g*AW +: AW];
    assign live_size[g]  = m_hsize[g*2 +: 2];
    assign live_trans[g] = m_htrans[g*2 +: 2];

    ahb_arb_hold_slot #(.AW(AW)) u_slot (
      .clk        (clk),
      .aresetn    (aresetn),
      .haddr      (live_addr[g]),
      .hsize      (live_size[g]),
      .htrans     (live_trans[g]),
      .hwrite     (m_hwrite[g]),
      .s_hready   (s_hready),
      .s_hresp    (s_hresp),
      .grant      (grant[g]),
      .req        (req[g]),
      .held       (held[g]),
      .hold_addr  (hold_addr[g]),
      .hold_size  (hold_size[g]),
      .hold_write (hold_write[g]),
      .hready     (m_hready[g]),
      .hresp      (m_hresp[g]),
      .state      (st[g])
    );
  end

`ifdef AHB_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

  assign prio_m1 = ~last_grant;
`else
  assign prio_m1 = 1'b0;
`endif

  assign cand  = req | held;
  assign gnt0  = s_hready && cand[0] && !(cand[1] && prio_m1);
  assign gnt1  = s_hready && cand[1] && !gnt0;
  assign grant = {gnt1, gnt0};
  assign win   = gnt1;

  // The data-phase owner is by construction the previous address-phase owner
  always_comb begin
    bus_addr  = bus_addr_q;
    bus_size  = bus_size_q;
    bus_trans = bus_trans_q;
    bus_write = bus_write_q;
    if (s_hready) begin
      bus_trans = HTRANS_IDLE;
      if (|grant) begin
        if (st[win] == SLOT_ADDR) begin
          bus_addr  = hold_addr[win];
          bus_size  = hold_size[win];
          bus_write = hold_write[win];
          bus_trans = HTRANS_NONSEQ;
        end else begin
          bus_addr  = live_addr[win];
          bus_size  = live_size[win];
          bus_write = m_hwrite[win];
          bus_trans = (dp_valid && dp_idx == win) ? live_trans[win] : HTRANS_NONSEQ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_trans_q <= HTRANS_IDLE;
      bus_write_q <= 1'b0;
      dp_valid    <= 1'b0;
      dp_idx      <= 1'b0;
    end else begin
      bus_addr_q  <= bus_addr;
      bus_size_q  <= bus_size;
      bus_trans_q <= bus_trans;
      bus_write_q <= bus_write;
      if (s_hready) begin
        dp_valid <= |grant;
        dp_idx   <= win;
      end
    end
  end

  assign s_haddr  = bus_addr;
  assign s_hsize  = bus_size;
  assign s_htrans = bus_trans;
  assign s_hwrite = bus_write;
  assign s_hwdata = dp_idx ? m_hwdata[2*DW-1:DW] : m_hwdata[DW-1:0];
  assign m_hrdata = s_hrdata;
  assign owner    = {dp_valid, dp_idx};

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for ahb_lite_arbiter2: scoreboard of expected slave address
// phases plus per-cycle checks of stall, response and owner signals.
module tb_ahb_lite_arbiter2;
  import ahb_lite_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [2*AW-1:0] m_haddr;
  logic [3:0]      m_hsize;
  logic [3:0]      m_htrans;
  logic [1:0]      m_hwrite;
  logic [2*DW-1:0] m_hwdata;
  logic [1:0]      m_hready;
  logic [DW-1:0]   m_hrdata;
  logic [1:0]      m_hresp;
  logic [AW-1:0]   s_haddr;
  logic [1:0]      s_hsize;
  logic [1:0]      s_htrans;
  logic            s_hwrite;
  logic [DW-1:0]   s_hwdata;
  logic            s_hready;
  logic [DW-1:0]   s_hrdata;
  logic            s_hresp;
  logic [1:0]      owner;

  ahb_lite_arbiter2 #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .m_haddr  (m_haddr),
    .m_hsize  (m_hsize),
    .m_htrans (m_htrans),
    .m_hwrite (m_hwrite),
    .m_hwdata (m_hwdata),
    .m_hready (m_hready),
    .m_hrdata (m_hrdata),
    .m_hresp  (m_hresp),
    .s_haddr  (s_haddr),
    .s_hsize  (s_hsize),
    .s_htrans (s_htrans),
    .s_hwrite (s_hwrite),
    .s_hwdata (s_hwdata),
    .s_hready (s_hready),
    .s_hrdata (s_hrdata),
    .s_hresp  (s_hresp),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [1:0]    trans;
  } xfer_t;

  xfer_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_xfer(input logic [AW-1:0] a, input logic w, input logic [1:0] t);
    xfer_t x;
    x.addr = a; x.write = w; x.trans = t;
    sb.push_back(x);
  endtask

  task automatic drive(input int unsigned i, input logic [1:0] t, input logic [AW-1:0] a,
                       input logic w);
    m_htrans[i*2 +: 2] = t;
    m_haddr[i*AW +: AW] = a;
    m_hwrite[i]         = w;
    m_hsize[i*2 +: 2]   = 2'b10;
  endtask

  task automatic idle_all();
    m_htrans = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Address phases accepted by the slave are popped and compared in order
  always @(negedge clk) begin
    if (aresetn && s_hready && s_htrans != HTRANS_IDLE) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        xfer_t x;
        x = sb.pop_front();
        check("sb_addr", 64'(s_haddr), 64'(x.addr));
        check("sb_write", 64'(s_hwrite), 64'(x.write));
        check("sb_trans", 64'(s_htrans), 64'(x.trans));
        check("sb_size", 64'(s_hsize), 64'd2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn  = 1'b0;
    m_haddr  = '0;
    m_hsize  = '0;
    m_htrans = '0;
    m_hwrite = '0;
    m_hwdata = '0;
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_hready", 64'(m_hready), 64'h3);
    check("rst_m_hresp", 64'(m_hresp), 64'h0);
    check("rst_s_htrans", 64'(s_htrans), 64'(HTRANS_IDLE));
    check("rst_s_hwrite", 64'(s_hwrite), 64'h0);
    check("rst_owner", 64'(owner), 64'h0);
    check("hrdata_bcast", 64'(m_hrdata), 64'hDEAD_BEEF);
    aresetn = 1'b1;
    nxt();

    // m0 alone: zero-latency write
    drive(0, HTRANS_NONSEQ, 32'h1000, 1'b1);
    expect_xfer(32'h1000, 1'b1, HTRANS_NONSEQ);
    @(negedge clk);
    check("t1_s_haddr", 64'(s_haddr), 64'h1000);
    check("t1_m_hready", 64'(m_hready), 64'h3);
    nxt();
    idle_all();
    m_hwdata = {32'h0000_1111, 32'hA5A5_5A5A};
    @(negedge clk);
    check("t1_owner", 64'(owner), 64'h2);
    check("t1_s_hwdata", 64'(s_hwdata), 64'hA5A5_5A5A);
    check("t1_m_hready_dp", 64'(m_hready), 64'h3);
    nxt();
    nxt();

    // m1 INCR4, m0 interleaves on beat 2
    drive(1, HTRANS_NONSEQ, 32'h400, 1'b0);
    expect_xfer(32'h400, 1'b0, HTRANS_NONSEQ);
    nxt();
    drive(1, HTRANS_SEQ, 32'h404, 1'b0);
    drive(0, HTRANS_NONSEQ, 32'h800, 1'b0);
    expect_xfer(32'h800, 1'b0, HTRANS_NONSEQ);
    expect_xfer(32'h404, 1'b0, HTRANS_NONSEQ);
    @(negedge clk);
    check("t3_m_hready_c1", 64'(m_hready), 64'h3);
    check("t3_s_haddr_c1", 64'(s_haddr), 64'h800);
    nxt();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_m_hready_c2", 64'(m_hready), 64'h1);
    check("t3_resume_trans", 64'(s_htrans), 64'(HTRANS_NONSEQ));
    check("t3_resume_addr", 64'(s_haddr), 64'h404);
    nxt();
    drive(1, HTRANS_SEQ, 32'h408, 1'b0);
    expect_xfer(32'h408, 1'b0, HTRANS_SEQ);
    @(negedge clk);
    check("t3_seq_pass", 64'(s_htrans), 64'(HTRANS_SEQ));
    check("t3_m_hready_c3", 64'(m_hready), 64'h3);
    nxt();
    drive(1, HTRANS_SEQ, 32'h40C, 1'b0);
    expect_xfer(32'h40C, 1'b0, HTRANS_SEQ);
    nxt();
    idle_all();
    nxt();
    nxt();

    // Simultaneous requests: m0 first, m1 replayed one cycle later
    drive(0, HTRANS_NONSEQ, 32'h100, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'h200, 1'b1);
    expect_xfer(32'h100, 1'b0, HTRANS_NONSEQ);
    expect_xfer(32'h200, 1'b1, HTRANS_NONSEQ);
    @(negedge clk);
    check("t2_s_haddr_c0", 64'(s_haddr), 64'h100);
    check("t2_m_hready_c0", 64'(m_hready), 64'h3);
    nxt();
    idle_all();
    m_hwdata = {32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    check("t2_m_hready_c1", 64'(m_hready), 64'h1);
    check("t2_s_haddr_c1", 64'(s_haddr), 64'h200);
    check("t2_s_htrans_c1", 64'(s_htrans), 64'(HTRANS_NONSEQ));
    check("t2_owner_c1", 64'(owner), 64'h2);
    nxt();
    @(negedge clk);
    check("t2_m_hready_c2", 64'(m_hready), 64'h3);
    check("t2_owner_c2", 64'(owner), 64'h3);
    check("t2_s_hwdata_c2", 64'(s_hwdata), 64'h2222_2222);
    nxt();
    nxt();

    // Two-cycle ERROR on m0 while m1 is held
    drive(0, HTRANS_NONSEQ, 32'h300, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'h600, 1'b1);
    expect_xfer(32'h300, 1'b0, HTRANS_NONSEQ);
    nxt();
    idle_all();
    s_hready = 1'b0;
    s_hresp  = 1'b1;
    expect_xfer(32'h600, 1'b1, HTRANS_NONSEQ);
    @(negedge clk);
    check("t4_m_hresp_e1", 64'(m_hresp), 64'h1);
    check("t4_m_hready_e1", 64'(m_hready), 64'h0);
    nxt();
    s_hready = 1'b1;
    @(negedge clk);
    check("t4_m_hresp_e2", 64'(m_hresp), 64'h1);
    check("t4_m_hready_e2", 64'(m_hready), 64'h1);
    check("t4_replay_addr", 64'(s_haddr), 64'h600);
    nxt();
    s_hresp = 1'b0;
    @(negedge clk);
    check("t4_m_hresp_ok", 64'(m_hresp), 64'h0);
    check("t4_owner", 64'(owner), 64'h3);
    nxt();
    nxt();

    // Three wait states while m1 is held
    drive(0, HTRANS_NONSEQ, 32'h700, 1'b1);
    drive(1, HTRANS_NONSEQ, 32'h900, 1'b0);
    expect_xfer(32'h700, 1'b1, HTRANS_NONSEQ);
    nxt();
    idle_all();
    s_hready = 1'b0;
    for (int unsigned w = 0; w < 3; w++) begin
      @(negedge clk);
      check("t5_wait_m_hready", 64'(m_hready), 64'h0);
      check("t5_wait_s_haddr", 64'(s_haddr), 64'h700);
      nxt();
    end
    s_hready = 1'b1;
    expect_xfer(32'h900, 1'b0, HTRANS_NONSEQ);
    @(negedge clk);
    check("t5_grant_m_hready", 64'(m_hready), 64'h1);
    check("t5_grant_s_haddr", 64'(s_haddr), 64'h900);
    nxt();
    @(negedge clk);
    check("t5_owner", 64'(owner), 64'h3);
    check("t5_m_hready_done", 64'(m_hready), 64'h3);
    nxt();
    nxt();

    // Reset while m1 is held: slot dropped, no replay
    drive(0, HTRANS_NONSEQ, 32'hA00, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'hB00, 1'b0);
    expect_xfer(32'hA00, 1'b0, HTRANS_NONSEQ);
    nxt();
    idle_all();
    s_hready = 1'b0;
    @(negedge clk);
    check("t6_pre_m_hready", 64'(m_hready), 64'h0);
    #1;
    aresetn = 1'b0;
    #1;
    check("t6_rst_m_hready", 64'(m_hready), 64'h3);
    check("t6_rst_s_htrans", 64'(s_htrans), 64'(HTRANS_IDLE));
    check("t6_rst_owner", 64'(owner), 64'h0);
    nxt();
    aresetn  = 1'b1;
    s_hready = 1'b1;
    @(negedge clk);
    check("t6_post_s_htrans", 64'(s_htrans), 64'(HTRANS_IDLE));
    check("t6_post_m_hready", 64'(m_hready), 64'h3);
    nxt();

    // Repeated contention: policy-dependent grant order
    drive(0, HTRANS_NONSEQ, 32'hC00, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'hD00, 1'b0);
    expect_xfer(32'hC00, 1'b0, HTRANS_NONSEQ);
`ifdef AHB_ARB_RR_EN
    expect_xfer(32'hD00, 1'b0, HTRANS_NONSEQ);
    expect_xfer(32'hC04, 1'b0, HTRANS_NONSEQ);
`else
    expect_xfer(32'hC04, 1'b0, HTRANS_NONSEQ);
    expect_xfer(32'hD00, 1'b0, HTRANS_NONSEQ);
`endif
    nxt();
    drive(0, HTRANS_NONSEQ, 32'hC04, 1'b0);
    drive(1, HTRANS_IDLE, 32'h0, 1'b0);
    @(negedge clk);
`ifdef AHB_ARB_RR_EN
    check("t7_c1_s_haddr", 64'(s_haddr), 64'hD00);
`else
    check("t7_c1_s_haddr", 64'(s_haddr), 64'hC04);
`endif
    check("t7_c1_m_hready", 64'(m_hready), 64'h1);
    nxt();
    idle_all();
    @(negedge clk);
`ifdef AHB_ARB_RR_EN
    check("t7_c2_s_haddr", 64'(s_haddr), 64'hC04);
    check("t7_c2_m_hready", 64'(m_hready), 64'h2);
`else
    check("t7_c2_s_haddr", 64'(s_haddr), 64'hD00);
    check("t7_c2_m_hready", 64'(m_hready), 64'h1);
`endif
    nxt();
    @(negedge clk);
    check("t7_c3_m_hready", 64'(m_hready), 64'h3);
`ifdef AHB_ARB_RR_EN
    check("t7_c3_owner", 64'(owner), 64'h2);
`else
    check("t7_c3_owner", 64'(owner), 64'h3);
`endif
    nxt();
    nxt();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
